// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults and types for the mac_sched multiply-accumulate scheduler.
//   NCH_DEF / DW_DEF / ZW_DEF : default channel count, operand width, result width
//   CHW_DEF                   : channel-index width for the default channel count
//   state_e                   : scheduler FSM states
//   chw()                     : channel-index width for any channel count (min 1 bit)
package mac_pkg;

   localparam int unsigned NCH_DEF = 4;
   localparam int unsigned DW_DEF  = 8;
   localparam int unsigned ZW_DEF  = 16;

   function automatic int unsigned chw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned CHW_DEF = chw(NCH_DEF);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_OUT
   } state_e;

endpackage

// File: rtl/mac_pipe.sv
// mac_pipe: two-stage signed multiply-accumulate datapath.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clear_i : zero product stage and accumulator (start of a burst)
//   en_i    : operand pair valid this cycle
//   a_i,b_i : signed DW-bit operands
//   acc_o   : signed ZW-bit accumulator, wraps modulo 2^ZW
// An operand pair accepted in cycle T is in the product register in T+1
// and included in acc_o from T+2.
module mac_pipe
   import mac_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned ZW = ZW_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic signed [DW-1:0] a_i,
   input  logic signed [DW-1:0] b_i,
   output logic signed [ZW-1:0] acc_o
);

   logic signed [ZW-1:0] a_x;
   logic signed [ZW-1:0] b_x;
   logic signed [ZW-1:0] prod_d;
   logic signed [ZW-1:0] prod_q;
   logic                 prod_vld_q;
   logic signed [ZW-1:0] acc_q;

   // Sign-extend both operands to the result width so the product is exact
   // modulo 2^ZW regardless of how the tool sizes the multiply.
   assign a_x    = {{(ZW-DW){a_i[DW-1]}}, a_i};
   assign b_x    = {{(ZW-DW){b_i[DW-1]}}, b_i};
   assign prod_d = a_x * b_x;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
      end else if (clear_i) begin
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
      end else begin
         prod_vld_q <= en_i;
         if (en_i) begin
            prod_q <= prod_d;
         end
         if (prod_vld_q) begin
            acc_q <= acc_q + prod_q;
         end
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mac_sched.sv
// mac_sched: round-robin scheduler feeding a shared signed MAC pipeline.
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   in_valid  : per-channel operand beat valid            [NCH]
//   in_ready  : per-channel beat accept (granted channel) [NCH]
//   in_a/in_b : per-channel signed operands, ch i at [i*DW +: DW]
//   in_last   : per-channel final beat of a burst         [NCH]
//   out_valid : dot-product result available
//   out_ready : result consumer accept
//   out_z     : signed dot-product result (wraps modulo 2^ZW)
//   out_ch    : channel that produced out_z
//   out_beats : accepted beats in the burst, saturating at 255
//   busy      : scheduler not idle
// One burst is served at a time; the grant is fixed from IDLE exit until the
// result handshake, after which the search pointer moves past the grant.
module mac_sched
   import mac_pkg::*;
#(
   parameter int unsigned NCH = NCH_DEF,
   parameter int unsigned DW  = DW_DEF,
   parameter int unsigned ZW  = ZW_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NCH-1:0]         in_valid,
   output logic [NCH-1:0]         in_ready,
   input  logic [NCH*DW-1:0]      in_a,
   input  logic [NCH*DW-1:0]      in_b,
   input  logic [NCH-1:0]         in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ZW-1:0]          out_z,
   output logic [chw(NCH)-1:0]    out_ch,
   output logic [7:0]             out_beats,
   output logic                   busy
);

   localparam int unsigned CHW = chw(NCH);

   state_e           state_q;
   logic [CHW-1:0]   grant_q;
   logic [CHW-1:0]   rr_q;
   logic [CHW-1:0]   rr_d;
   logic [7:0]       beats_q;
   logic             drain_q;
   logic [NCH-1:0]   in_ready_q;
   logic             out_valid_q;
   logic [ZW-1:0]    out_z_q;
   logic [CHW-1:0]   out_ch_q;
   logic [7:0]       out_beats_q;
   logic             busy_q;

   logic             req_any;
   logic [CHW-1:0]   pick;
   logic [NCH-1:0]   pick_oh;
   logic             accept;
   logic             pipe_clear;
   logic signed [ZW-1:0] acc;

   // Round-robin search: first requester at or after rr_q, wrapping.
   always_comb begin
      int unsigned idx;
      logic        found;
      logic [CHW-1:0] cand;
      req_any = |in_valid;
      pick    = '0;
      pick_oh = '0;
      found   = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         idx = 32'(rr_q) + k;
         if (idx >= NCH) begin
            idx = idx - NCH;
         end
         cand = CHW'(idx);
         if (!found && in_valid[cand]) begin
            found         = 1'b1;
            pick          = cand;
            pick_oh[cand] = 1'b1;
         end
      end
   end

   assign accept     = (state_q == S_STREAM) & in_valid[grant_q] & in_ready_q[grant_q];
   assign pipe_clear = (state_q == S_IDLE) & req_any;
   assign rr_d       = (grant_q == CHW'(NCH-1)) ? '0 : grant_q + 1'b1;

   mac_pipe #(
      .DW (DW),
      .ZW (ZW)
   ) u_pipe (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .clear_i (pipe_clear),
      .en_i    (accept),
      .a_i     (in_a[grant_q*DW +: DW]),
      .b_i     (in_b[grant_q*DW +: DW]),
      .acc_o   (acc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         rr_q        <= '0;
         beats_q     <= '0;
         drain_q     <= 1'b0;
         in_ready_q  <= '0;
         out_valid_q <= 1'b0;
         out_z_q     <= '0;
         out_ch_q    <= '0;
         out_beats_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_any) begin
                  grant_q    <= pick;
                  beats_q    <= '0;
                  in_ready_q <= pick_oh;
                  busy_q     <= 1'b1;
                  state_q    <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (accept) begin
                  if (beats_q != 8'hFF) begin
                     beats_q <= beats_q + 8'd1;
                  end
                  if (in_last[grant_q]) begin
                     in_ready_q <= '0;
                     drain_q    <= 1'b0;
                     state_q    <= S_DRAIN;
                  end
               end
            end
            // Two cycles let the last beat pass the product and accumulate stages.
            S_DRAIN: begin
               if (drain_q) begin
                  out_valid_q <= 1'b1;
                  out_z_q     <= acc;
                  out_ch_q    <= grant_q;
                  out_beats_q <= beats_q;
                  state_q     <= S_OUT;
               end else begin
                  drain_q <= 1'b1;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  rr_q        <= rr_d;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_z     = out_z_q;
   assign out_ch    = out_ch_q;
   assign out_beats = out_beats_q;
   assign busy      = busy_q;

endmodule
